cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/cdb_arbiter_rr_arbiter.sv | 31 +++
 rtl/cdb_arbiter.sv | 99 +++++++++
 tb/tb_cdb_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared RV32I core types: functional-unit inventory and the common data bus entry.
package rv32i_types;

  localparam int NUM_ALU    = 2;
  localparam int NUM_MUL    = 1;
  localparam int NUM_LSU    = 1;
  localparam int TOTAL_FU   = NUM_ALU + NUM_MUL + NUM_LSU;
  localparam int FU_ID_W    = (TOTAL_FU > 1) ? $clog2(TOTAL_FU) : 1;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ORDER_W    = 64;

  typedef logic [FU_ID_W-1:0] fu_id_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    fu_id_t                fu_id;
    logic [ORDER_W-1:0]    order;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [WIDTH-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < WIDTH; off++) begin
      // Rotate the search origin to ptr, folding indices past the top back to 0.
      idx = int'(ptr) + off;
      if (idx >= WIDTH) begin
        idx = idx - WIDTH;
      end
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one completed FU result per cycle and broadcasts it a cycle later.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU = TOTAL_FU
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             req_valid,
  input  logic [NUM_FU-1:0][4:0]        req_rd,
  input  logic [NUM_FU-1:0][31:0]       req_data,
  input  logic [NUM_FU-1:0][63:0]       req_order,
  output logic [NUM_FU-1:0]             grant,
  output logic                          cdb_valid,
  output cdb_entry_t                    cdb_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_rd,
  output logic [31:0]                   rf_wdata
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  ptr_next;
  logic [NUM_FU-1:0] req_masked;
  logic [NUM_FU-1:0] gnt;
  logic [PTR_W-1:0]  win_idx;
  logic              any_gnt;
  cdb_entry_t        cand [NUM_FU];
  cdb_entry_t        win_entry;
  cdb_entry_t        cdb_data_reg;
  logic              cdb_valid_reg;

  // A flushed or reset cycle simply presents no requests, so the pointer cannot move.
  assign req_masked = (rst || flush) ? '0 : req_valid;

  rr_arbiter #(
    .WIDTH (NUM_FU),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (req_masked),
    .ptr (ptr_reg),
    .gnt (gnt)
  );

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_cand
      assign cand[gi] = '{rd:    req_rd[gi],
                          data:  req_data[gi],
                          fu_id: fu_id_t'(gi),
                          order: req_order[gi]};
    end
  endgenerate

  // gnt is one-hot, so an OR of the gated candidates is a mux without a priority chain.
  always_comb begin
    win_entry = '0;
    win_idx   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i]) begin
        win_entry = win_entry | cand[i];
        win_idx   = win_idx | PTR_W'(i);
      end
    end
  end

  assign any_gnt = |gnt;

  always_comb begin
    ptr_next = ptr_reg;
    if (any_gnt) begin
      ptr_next = (win_idx == PTR_W'(NUM_FU - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      cdb_valid_reg <= 1'b0;
      cdb_data_reg  <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      cdb_valid_reg <= any_gnt;
      if (any_gnt) begin
        cdb_data_reg <= win_entry;
      end
    end
  end

  assign grant     = gnt;
  assign cdb_valid = cdb_valid_reg;
  assign cdb_data  = cdb_data_reg;
  // An entry still registered when reset arrives must not reach the register file.
  assign rf_we     = cdb_valid_reg && (cdb_data_reg.rd != 5'd0) && !rst;
  assign rf_rd     = cdb_data_reg.rd;
  assign rf_wdata  = cdb_data_reg.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, then a random valid-hold run with a starvation bound.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N = 4;

  logic                clk;
  logic                rst;
  logic                flush;
  logic [N-1:0]        req_valid;
  logic [N-1:0][4:0]   req_rd;
  logic [N-1:0][31:0]  req_data;
  logic [N-1:0][63:0]  req_order;
  logic [N-1:0]        grant;
  logic                cdb_valid;
  cdb_entry_t          cdb_data;
  logic                rf_we;
  logic [4:0]          rf_rd;
  logic [31:0]         rf_wdata;

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_order (req_order),
    .grant     (grant),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [N-1:0] req;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [N-1:0] exp_gnt;
    logic        zero_data;
  } vec_t;

  vec_t       vecs [$];
  cdb_entry_t sb   [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_same(input logic r, input logic f, input logic [N-1:0] req,
                            input logic [4:0] rd, input logic [31:0] base, input int tag);
    rst       = r;
    flush     = f;
    req_valid = req;
    for (int i = 0; i < N; i++) begin
      req_rd[i]    = rd;
      req_data[i]  = base ^ (32'(i ^ 2) << 24);
      req_order[i] = {32'(tag), 32'(i)};
    end
  endtask

  // Mid-cycle: check the registered entry against the scoreboard, then the grant,
  // and queue what the grant should produce on the next cycle.
  task automatic do_cycle(input logic [N-1:0] exp_gnt, input logic zero_data);
    cdb_entry_t e;
    #4;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cdb_valid", 64'(cdb_valid), 64'd1);
      check("fu_id", 64'(cdb_data.fu_id), 64'(e.fu_id));
      check("cdb_rd", 64'(cdb_data.rd), 64'(e.rd));
      check("cdb_data", 64'(cdb_data.data), 64'(e.data));
      check("cdb_order", cdb_data.order, e.order);
      check("rf_we", 64'(rf_we), 64'((e.rd != 5'd0) && !rst));
      check("rf_rd", 64'(rf_rd), 64'(e.rd));
      check("rf_wdata", 64'(rf_wdata), 64'(e.data));
    end else begin
      check("cdb_valid_idle", 64'(cdb_valid), 64'd0);
      check("rf_we_idle", 64'(rf_we), 64'd0);
    end
    if (zero_data) begin
      check("cdb_data_reset", 64'(cdb_data.data), 64'd0);
      check("cdb_order_reset", cdb_data.order, 64'd0);
    end
    check("grant", 64'(grant), 64'(exp_gnt));
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) begin
        e.rd    = req_rd[i];
        e.data  = req_data[i];
        e.fu_id = fu_id_t'(i);
        e.order = req_order[i];
        sb.push_back(e);
      end
    end
    $display("[TB] cyc %0d rst=%0b flush=%0b req=%b grant=%b exp=%b cdb_v=%0b fu=%0d rf_we=%0b",
             cyc, rst, flush, req_valid, grant, exp_gnt, cdb_valid, cdb_data.fu_id, rf_we);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [N-1:0] model_rr(input logic [N-1:0] req, input int p);
    logic [N-1:0] g;
    g = '0;
    for (int k = 0; k < N; k++) begin
      if (g == '0 && req[(p + k) % N]) g[(p + k) % N] = 1'b1;
    end
    return g;
  endfunction

  logic        pend   [N];
  int          waited [N];
  logic [4:0]  p_rd   [N];
  logic [31:0] p_data [N];
  logic [N-1:0] eg;
  int          mptr;

  initial begin
    //                rst  flush req      rd     data           exp_gnt  zero
    vecs.push_back('{1'b1, 1'b0, 4'b1111, 5'd7, 32'h1111_0000, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 4'b1111, 5'd7, 32'h1111_0000, 4'b0000, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 4'b1111, 5'd7, 32'h1111_0000, 4'b0001, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 4'b0100, 5'd5, 32'hDEAD_BEEF, 4'b0100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b1001, 5'd9, 32'h0000_3333, 4'b1000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0001, 5'd9, 32'h0000_4444, 4'b0001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b1000, 5'd1, 32'h0000_5555, 4'b1000, 1'b0});
    for (int r = 0; r < 2; r++) begin
      vecs.push_back('{1'b0, 1'b0, 4'b1011, 5'd10, 32'hA000_0000 + 32'(r), 4'b0001, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 4'b1011, 5'd11, 32'hB000_0000 + 32'(r), 4'b0010, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 4'b1011, 5'd12, 32'hC000_0000 + 32'(r), 4'b1000, 1'b0});
    end
    vecs.push_back('{1'b0, 1'b0, 4'b0010, 5'd0,  32'h0BAD_F00D, 4'b0010, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b0001, 5'd3,  32'h0000_0666, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 5'd3,  32'h0000_0777, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0101, 5'd4,  32'h0000_0888, 4'b0100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0001, 5'd6,  32'h0000_0999, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'b1111, 5'd8,  32'h0000_0AAA, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b1111, 5'd8,  32'h0000_0BBB, 4'b0001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'd8,  32'h0000_0CCC, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'd8,  32'h0000_0DDD, 4'b0000, 1'b0});

    drive_same(1'b1, 1'b0, 4'b1111, 5'd7, 32'h1111_0000, 0);
    @(posedge clk);
    #1;

    for (int v = 0; v < vecs.size(); v++) begin
      drive_same(vecs[v].rst, vecs[v].flush, vecs[v].req, vecs[v].rd, vecs[v].data, v + 1);
      do_cycle(vecs[v].exp_gnt, vecs[v].zero_data);
    end

    // Random valid-hold traffic from a fresh reset; each FU must win within N cycles.
    drive_same(1'b1, 1'b0, 4'b0000, 5'd0, 32'h0, 0);
    do_cycle(4'b0000, 1'b0);
    mptr = 0;
    for (int i = 0; i < N; i++) begin
      pend[i]   = 1'b0;
      waited[i] = 0;
    end
    rst = 1'b0;
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 3) != 0)) begin
          pend[i]   = 1'b1;
          waited[i] = 0;
          p_rd[i]   = 5'($urandom_range(0, 31));
          p_data[i] = $urandom;
        end
        req_valid[i] = pend[i];
        req_rd[i]    = p_rd[i];
        req_data[i]  = p_data[i];
        req_order[i] = {32'(1000 + t), 32'(i)};
      end
      eg = model_rr(req_valid, mptr);
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          check("starvation_wait", 64'(waited[i] < N), 64'd1);
          pend[i] = 1'b0;
          mptr    = (i + 1) % N;
        end else if (pend[i]) begin
          waited[i]++;
        end
      end
      do_cycle(eg, 1'b0);
    end

    req_valid = '0;
    do_cycle(4'b0000, 1'b0);
    do_cycle(4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
